// File: rtl/reg_file_pkg.sv
// Shared constants and types for the register file / busy scoreboard.
package reg_file_pkg;

    // Ceiling log2, usable in parameter expressions; returns at least 1.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return (res < 1) ? 1 : res;
    endfunction

    // Architectural zero register address.
    localparam int ZERO_ADDR = 0;

    // Default 32 x 32 configuration.
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_AW     = clog2(DEF_DEPTH);

    typedef logic [DEF_AW-1:0]     rf_addr_t;
    typedef logic [DEF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: storage mux, write-first bypass and busy select.
module reg_file_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic [AW-1:0]                  rd_addr_i,
    input  logic [DEPTH-1:0][DATA_W-1:0]   regs_i,
    input  logic [DEPTH-1:0]               busy_i,
    input  logic                           wr_en_i,
    input  logic [AW-1:0]                  wr_addr_i,
    input  logic [DATA_W-1:0]              wr_data_i,
    output logic [DATA_W-1:0]              rd_data_o,
    output logic                           rd_busy_o
);

    logic is_zero;
    logic bypass;

    // r0 is hardwired only when ZERO_REG is set; it never bypasses.
    assign is_zero = (ZERO_REG != 0) && (rd_addr_i == AW'(ZERO_ADDR));
    assign bypass  = wr_en_i && (wr_addr_i == rd_addr_i) && !is_zero;

    // Select stored value, override with in-flight write, force zero for r0.
    always_comb begin
        rd_data_o = regs_i[rd_addr_i];
        rd_busy_o = busy_i[rd_addr_i];
        if (bypass) begin
            rd_data_o = wr_data_i;
            rd_busy_o = 1'b0;
        end
        if (is_zero) begin
            rd_data_o = '0;
            rd_busy_o = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Register file with per-register busy scoreboard: NUM_RD read ports, one
// write port (writeback, clears busy) and one reserve port (decode, sets busy).
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [AW-1:0]            rsv_addr,
    output logic                     rsv_ok
);

    logic [DEPTH-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]             busy_q, busy_d;

    logic wr_zero, rsv_zero;
    logic wr_take, rsv_take;

    assign wr_zero  = (ZERO_REG != 0) && (wr_addr  == AW'(ZERO_ADDR));
    assign rsv_zero = (ZERO_REG != 0) && (rsv_addr == AW'(ZERO_ADDR));

    // Reservation uses the pre-edge busy bit; r0 always accepts but never latches.
    assign rsv_ok   = rsv_en && (rsv_zero || !busy_q[rsv_addr]);
    assign wr_take  = wr_en && !wr_zero;
    assign rsv_take = rsv_ok && !rsv_zero;

    // Next state: write clears busy, then an accepted reserve sets it, so a
    // same-address write+reserve on a free register ends busy (new producer owns it).
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_take) begin
            regs_d[wr_addr] = wr_data;
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_take) begin
            busy_d[rsv_addr] = 1'b1;
        end
    end

    // Storage and scoreboard; reset wins over any concurrent write or reserve.
    always_ff @(posedge clock) begin
        if (reset) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // One read port instance per decode operand.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        reg_file_read_port #(
            .DATA_W  (DATA_W),
            .DEPTH   (DEPTH),
            .ZERO_REG(ZERO_REG)
        ) u_port (
            .rd_addr_i(rd_addr[p*AW +: AW]),
            .regs_i   (regs_q),
            .busy_i   (busy_q),
            .wr_en_i  (wr_en),
            .wr_addr_i(wr_addr),
            .wr_data_i(wr_data),
            .rd_data_o(rd_data[p*DATA_W +: DATA_W]),
            .rd_busy_o(rd_busy[p])
        );
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboard bench: stimulus queues expected outputs, a negedge monitor checks them.
module tb_reg_file_scoreboard;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Default instance: 32 x 32, two read ports.
    logic [9:0]  rd_addr_a;
    logic [63:0] rd_data_a;
    logic [1:0]  rd_busy_a;
    logic        wr_en_a;
    logic [4:0]  wr_addr_a;
    logic [31:0] wr_data_a;
    logic        rsv_en_a;
    logic [4:0]  rsv_addr_a;
    logic        rsv_ok_a;

    // Wide instance: 16 x 64, three read ports.
    logic [11:0]  rd_addr_b;
    logic [191:0] rd_data_b;
    logic [2:0]   rd_busy_b;
    logic         wr_en_b;
    logic [3:0]   wr_addr_b;
    logic [63:0]  wr_data_b;
    logic         rsv_en_b;
    logic [3:0]   rsv_addr_b;
    logic         rsv_ok_b;

    reg_file_scoreboard u_dut_a (
        .clock(clock), .reset(reset),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .rsv_en(rsv_en_a), .rsv_addr(rsv_addr_a), .rsv_ok(rsv_ok_a)
    );

    reg_file_scoreboard #(.DATA_W(64), .DEPTH(16), .NUM_RD(3), .ZERO_REG(1)) u_dut_b (
        .clock(clock), .reset(reset),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .rsv_en(rsv_en_b), .rsv_addr(rsv_addr_b), .rsv_ok(rsv_ok_b)
    );

    // kind: 0 rd_data, 1 rd_busy, 2 rsv_ok ; inst: 0 default, 1 wide
    typedef struct {
        int          inst;
        int          kind;
        int          port;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic push(input int inst, input int kind, input int port,
                        input logic [63:0] v, input string name);
        exp_t e;
        e.inst = inst; e.kind = kind; e.port = port; e.exp = v; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic exp_rd(input int p, input logic [63:0] v, input string n);
        push(0, 0, p, v, n);
    endtask
    task automatic exp_busy(input int p, input logic [63:0] v, input string n);
        push(0, 1, p, v, n);
    endtask
    task automatic exp_ok(input logic [63:0] v, input string n);
        push(0, 2, 0, v, n);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr_a = {5'(a1), 5'(a0)};
    endtask

    // Monitor: every negedge, drain and compare whatever the stimulus queued.
    initial begin
        exp_t        e;
        logic [63:0] act;
        forever begin
            @(negedge clock);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = '0;
                if (e.inst == 0) begin
                    case (e.kind)
                        0: act = {32'b0, rd_data_a[e.port*32 +: 32]};
                        1: act = {63'b0, rd_busy_a[e.port]};
                        default: act = {63'b0, rsv_ok_a};
                    endcase
                end else begin
                    case (e.kind)
                        0: act = rd_data_b[e.port*64 +: 64];
                        1: act = {63'b0, rd_busy_b[e.port]};
                        default: act = {63'b0, rsv_ok_b};
                    endcase
                end
                n_chk++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        rd_addr_a = '0; wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
        rsv_en_a = 1'b0; rsv_addr_a = '0;
        rd_addr_b = '0; wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
        rsv_en_b = 1'b0; rsv_addr_b = '0;
        step();

        // 1. reset: rsv_ok follows rsv_en, then everything reads zero and idle
        rsv_en_a = 1'b1; rsv_addr_a = 5'd4;
        exp_ok(1, "reset_rsv_ok");
        step();
        reset = 1'b0; rsv_en_a = 1'b0;
        for (int a = 0; a < 32; a++) begin
            set_rd(a, 31 - a);
            exp_rd(0, 0, "reset_rd0"); exp_rd(1, 0, "reset_rd1");
            exp_busy(0, 0, "reset_busy0"); exp_busy(1, 0, "reset_busy1");
            step();
        end

        // 2. write r5 with same-cycle read -> bypass, then stored value
        wr_en_a = 1'b1; wr_addr_a = 5'd5; wr_data_a = 32'hDEADBEEF;
        set_rd(5, 6);
        exp_rd(0, 64'hDEADBEEF, "bypass_r5"); exp_busy(0, 0, "bypass_busy_r5");
        exp_rd(1, 0, "no_bypass_r6");
        step();
        wr_en_a = 1'b0;
        exp_rd(0, 64'hDEADBEEF, "stored_r5");
        step();

        // 3. r0 hardwired: write dropped, reserve is accepted no-op
        wr_en_a = 1'b1; wr_addr_a = 5'd0; wr_data_a = 32'h1234;
        set_rd(0, 0);
        exp_rd(0, 0, "r0_write_same_cycle");
        step();
        wr_en_a = 1'b0;
        rsv_en_a = 1'b1; rsv_addr_a = 5'd0;
        exp_rd(1, 0, "r0_after_write"); exp_ok(1, "r0_rsv_ok");
        step();
        rsv_en_a = 1'b0;
        exp_busy(0, 0, "r0_never_busy"); exp_rd(0, 0, "r0_still_zero");
        step();

        // 4. reserve r7, re-reserve rejected, write clears busy with bypass
        rsv_en_a = 1'b1; rsv_addr_a = 5'd7;
        set_rd(7, 7);
        exp_ok(1, "rsv_r7_ok"); exp_busy(0, 0, "r7_busy_pre_edge");
        step();
        exp_busy(0, 1, "r7_busy"); exp_ok(0, "rsv_r7_reject");
        step();
        rsv_en_a = 1'b0;
        wr_en_a = 1'b1; wr_addr_a = 5'd7; wr_data_a = 32'h55;
        exp_busy(0, 0, "r7_bypass_busy"); exp_rd(0, 64'h55, "r7_bypass_data");
        exp_busy(1, 0, "r7_bypass_busy_p1");
        step();
        wr_en_a = 1'b0;
        exp_busy(0, 0, "r7_busy_cleared"); exp_rd(1, 64'h55, "r7_stored");
        step();

        // 5. write+reserve r3 while free -> accepted, ends busy
        wr_en_a = 1'b1; wr_addr_a = 5'd3; wr_data_a = 32'hA;
        rsv_en_a = 1'b1; rsv_addr_a = 5'd3;
        set_rd(3, 3);
        exp_ok(1, "wr_rsv_r3_ok"); exp_rd(0, 64'hA, "wr_rsv_r3_bypass");
        step();
        wr_en_a = 1'b0; rsv_en_a = 1'b0;
        exp_busy(0, 1, "r3_busy_after"); exp_rd(0, 64'hA, "r3_stored");
        step();
        //    write+reserve r3 while busy -> rejected, write clears busy
        wr_en_a = 1'b1; wr_data_a = 32'hB; rsv_en_a = 1'b1;
        exp_ok(0, "wr_rsv_r3_busy_reject");
        step();
        wr_en_a = 1'b0; rsv_en_a = 1'b0;
        exp_busy(0, 0, "r3_cleared"); exp_rd(0, 64'hB, "r3_new_data");
        step();
        //    different addresses are independent
        wr_en_a = 1'b1; wr_addr_a = 5'd13; wr_data_a = 32'h77;
        rsv_en_a = 1'b1; rsv_addr_a = 5'd12;
        exp_ok(1, "rsv_r12_ok");
        step();
        wr_en_a = 1'b0; rsv_en_a = 1'b0;
        set_rd(12, 13);
        exp_busy(0, 1, "r12_busy"); exp_busy(1, 0, "r13_idle");
        exp_rd(1, 64'h77, "r13_data");
        step();

        // 6. reset mid-operation forgets the reservation and the data
        wr_en_a = 1'b1; wr_addr_a = 5'd9; wr_data_a = 32'h99;
        step();
        wr_en_a = 1'b0;
        rsv_en_a = 1'b1; rsv_addr_a = 5'd9;
        set_rd(9, 5);
        exp_ok(1, "rsv_r9_ok");
        step();
        rsv_en_a = 1'b0; reset = 1'b1;
        exp_busy(0, 1, "r9_busy"); exp_rd(0, 64'h99, "r9_data");
        step();
        reset = 1'b0;
        exp_busy(0, 0, "r9_busy_reset"); exp_rd(0, 0, "r9_data_reset");
        exp_rd(1, 0, "r5_data_reset");
        step();
        //    the forgotten producer's late write lands normally
        wr_en_a = 1'b1; wr_addr_a = 5'd9; wr_data_a = 32'h42;
        step();
        wr_en_a = 1'b0;
        exp_rd(0, 64'h42, "r9_late_write"); exp_busy(0, 0, "r9_late_idle");
        step();

        // Wide configuration smoke: three independent ports
        wr_en_b = 1'b1; wr_addr_b = 4'd1; wr_data_b = 64'h1111_2222_3333_4444;
        step();
        wr_addr_b = 4'd2; wr_data_b = 64'h5555_6666_7777_8888;
        step();
        wr_addr_b = 4'd15; wr_data_b = 64'h9999_AAAA_BBBB_CCCC;
        step();
        wr_en_b = 1'b0;
        rd_addr_b = {4'd15, 4'd2, 4'd1};
        push(1, 0, 0, 64'h1111_2222_3333_4444, "w_p0_r1");
        push(1, 0, 1, 64'h5555_6666_7777_8888, "w_p1_r2");
        push(1, 0, 2, 64'h9999_AAAA_BBBB_CCCC, "w_p2_r15");
        push(1, 2, 0, 0, "w_rsv_ok_idle");
        step();
        wr_en_b = 1'b1; wr_addr_b = 4'd4; wr_data_b = 64'hFEDC_BA98_7654_3210;
        rd_addr_b = {4'd1, 4'd4, 4'd15};
        push(1, 0, 0, 64'h9999_AAAA_BBBB_CCCC, "w_p0_r15");
        push(1, 0, 1, 64'hFEDC_BA98_7654_3210, "w_p1_bypass_r4");
        push(1, 0, 2, 64'h1111_2222_3333_4444, "w_p2_r1");
        push(1, 1, 1, 0, "w_p1_busy");
        step();
        wr_en_b = 1'b0;
        step();
        step();

        rd_addr_b = {4'd4, 4'd2, 4'd1};
        #1;
        n_chk++;
        if (rd_data_b[0 +: 64] !== 64'h1111_2222_3333_4444) begin
            n_fail++;
            $display("FAIL w_direct_p0_r1: got %h, expected %h", rd_data_b[0 +: 64], 64'h1111_2222_3333_4444);
        end
        n_chk++;
        if (rd_data_b[64 +: 64] !== 64'h5555_6666_7777_8888) begin
            n_fail++;
            $display("FAIL w_direct_p1_r2: got %h, expected %h", rd_data_b[64 +: 64], 64'h5555_6666_7777_8888);
        end
        n_chk++;
        if (rd_data_b[128 +: 64] !== 64'hFEDC_BA98_7654_3210) begin
            n_fail++;
            $display("FAIL w_direct_p2_r4: got %h, expected %h", rd_data_b[128 +: 64], 64'hFEDC_BA98_7654_3210);
        end
        n_chk++;
        if (rd_busy_b !== 3'b000) begin
            n_fail++;
            $display("FAIL w_direct_busy: got %b, expected %b", rd_busy_b, 3'b000);
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: got %0d, expected %0d", exp_q.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
